// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : shared UART types, constants and frame-width helper             |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_START   = 3'd1,
    RX_DATA    = 3'd2,
    RX_PARITY  = 3'd3,
    RX_STOP    = 3'd4,
    RX_BRKWAIT = 3'd5
  } rx_state_t;

  localparam logic c_line_idle   = 1'b1;
  localparam int   c_parity_even = 0;
  localparam int   c_parity_odd  = 1;

  function automatic int frame_width(input int data_bits, input int parity_en,
                                     input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_sync : 2-FF synchronizer with registered falling-edge detect       |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rxs,
  output logic fall_edge
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= c_line_idle;
      r_sync <= c_line_idle;
      r_prev <= c_line_idle;
    end else begin
      r_meta <= rx_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rxs       = r_sync;
  assign fall_edge = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_ctrl : oversampling UART receive sequencer with pending/ack status |
// | Option       : UART_RX_MAJORITY_VOTE_EN selects 2-of-3 bit voting          |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter  int DATA_BITS  = 8,
  parameter  int PARITY_EN  = 1,
  parameter  int PARITY_ODD = c_parity_even,
  parameter  int STOP_BITS  = 1,
  parameter  int OVERSAMPLE = 16,
  localparam int FRAME_W    = frame_width(DATA_BITS, PARITY_EN, STOP_BITS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               baud_tick,
  input  logic               rx_in,
  input  logic               frame_ack,
  output logic [FRAME_W-1:0] frame_out,
  output logic               received_flag,
  output logic               frame_pending,
  output logic               parity_err,
  output logic               framing_err,
  output logic               overrun_err,
  output logic               busy
);

  localparam int c_cnt_w  = $clog2(OVERSAMPLE);
  localparam int c_bcnt_w = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int c_vote_lag = 1;
`else
  localparam int c_vote_lag = 0;
`endif
  // With voting the decision lands one tick after the centre sample; the
  // start-bit point shifts by that tick so later bit centres are unchanged.
  localparam logic [c_cnt_w-1:0]  c_start_pt  = c_cnt_w'(OVERSAMPLE / 2 - 1 + c_vote_lag);
  localparam logic [c_cnt_w-1:0]  c_bit_pt    = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_bcnt_w-1:0] c_last_data = c_bcnt_w'(DATA_BITS - 1);
  localparam logic [c_bcnt_w-1:0] c_last_stop = c_bcnt_w'(STOP_BITS - 1);
  localparam logic                c_odd       = (PARITY_ODD == c_parity_odd);

  logic                w_rxs;
  logic                w_fall;
  logic                w_bit;
  rx_state_t           r_state;
  rx_state_t           w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [c_bcnt_w-1:0] r_bcnt;
  logic [FRAME_W-2:0]  r_shift;
  logic                r_par;
  logic                r_perr;
  logic                r_ferr;
  logic                w_cnt_clr;
  logic                w_take;
  logic                w_done;
  logic                w_tick_pt;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .rxs       (w_rxs),
    .fall_edge (w_fall)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] r_vote;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vote <= {2{c_line_idle}};
    end else if (baud_tick) begin
      r_vote <= {r_vote[0], w_rxs};
    end
  end

  assign w_bit = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rxs) | (r_vote[0] & w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  assign w_tick_pt = baud_tick && (r_cnt == c_bit_pt);
  assign busy      = (r_state != RX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_take      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (w_fall) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (baud_tick && (r_cnt == c_start_pt)) begin
          w_cnt_clr = 1'b1;
          if (w_bit == 1'b0) begin
            w_take      = 1'b1;
            w_state_nxt = RX_DATA;
          end else begin
            w_state_nxt = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (w_tick_pt) begin
          w_cnt_clr = 1'b1;
          w_take    = 1'b1;
          if (r_bcnt == c_last_data) begin
            w_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
          end
        end
      end
      RX_PARITY: begin
        if (w_tick_pt) begin
          w_cnt_clr   = 1'b1;
          w_take      = 1'b1;
          w_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (w_tick_pt) begin
          w_cnt_clr = 1'b1;
          w_take    = 1'b1;
          if (r_bcnt == c_last_stop) begin
            w_done      = 1'b1;
            // A low final stop bit means a break; wait for the line to rise.
            w_state_nxt = w_bit ? RX_IDLE : RX_BRKWAIT;
          end
        end
      end
      RX_BRKWAIT: begin
        if (w_rxs) begin
          w_state_nxt = RX_IDLE;
        end
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (baud_tick) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_state_nxt != r_state) begin
        r_bcnt <= '0;
      end else if (w_take) begin
        r_bcnt <= r_bcnt + 1'b1;
      end
      if (w_take) begin
        r_shift <= {w_bit, r_shift[FRAME_W-2:1]};
      end
      if (r_state == RX_IDLE) begin
        r_par  <= 1'b0;
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end else if (w_take) begin
        case (r_state)
          RX_DATA:   r_par  <= r_par ^ w_bit;
          RX_PARITY: r_perr <= w_bit ^ r_par ^ c_odd;
          RX_STOP:   r_ferr <= r_ferr | ~w_bit;
          default:   ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_out     <= '0;
      received_flag <= 1'b0;
      frame_pending <= 1'b0;
      parity_err    <= 1'b0;
      framing_err   <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      received_flag <= w_done;
      if (w_done) begin
        frame_out     <= {w_bit, r_shift};
        parity_err    <= r_perr;
        framing_err   <= r_ferr | ~w_bit;
        frame_pending <= 1'b1;
        // A same-cycle ack retires the old frame, so no overrun then.
        overrun_err   <= ~frame_ack & (frame_pending | overrun_err);
      end else if (frame_ack) begin
        frame_pending <= 1'b0;
        overrun_err   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_rx_ctrl : directed self-checking bench for uart_rx_ctrl            |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        baud_tick;
  logic        rx_in;
  logic        frame_ack;
  logic [10:0] frame_out;
  logic        received_flag;
  logic        frame_pending;
  logic        parity_err;
  logic        framing_err;
  logic        overrun_err;
  logic        busy;

  int n_tests  = 0;
  int n_fail   = 0;
  int flag_cnt = 0;
  int bc       = 0;

  uart_rx_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx_in         (rx_in),
    .frame_ack     (frame_ack),
    .frame_out     (frame_out),
    .received_flag (received_flag),
    .frame_pending (frame_pending),
    .parity_err    (parity_err),
    .framing_err   (framing_err),
    .overrun_err   (overrun_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // One baud tick every 4 clocks: 64 clocks per bit at OVERSAMPLE=16.
  initial begin
    baud_tick = 1'b0;
    forever begin
      @(negedge clk);
      bc = (bc + 1) % 4;
      baud_tick = (bc == 0);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (received_flag) flag_cnt++;
    end
  end

  // Frame start is aligned so the stop-bit decision lands 674 clocks after
  // the start-bit drive; ack_at/rst_at are offsets in that same clock count.
  task automatic send_frame(input logic [10:0] f, input int ack_at, input int rst_at,
                            input logic idle_after);
    @(posedge clk);
    while (!baud_tick) @(posedge clk);
    repeat (2) @(negedge clk);
    rx_in = f[0];
    for (int n = 1; n <= 704; n++) begin
      @(negedge clk);
      if (n == rst_at) begin
        rst   = 1'b1;
        rx_in = 1'b1;
        return;
      end
      if (ack_at >= 0) frame_ack = (n == ack_at);
      if (n == 704) rx_in = idle_after;
      else if (n % 64 == 0) rx_in = f[n / 64];
    end
  endtask

  task automatic pulse_ack;
    @(negedge clk);
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; rx_in = 1'b1; frame_ack = 1'b0;
    repeat (4) @(negedge clk);
    n_tests++;
    if (frame_out !== 11'h000) begin n_fail++; $display("FAIL reset_frame: got %h want 000", frame_out); end
    n_tests++;
    if ({received_flag, frame_pending, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: flag/pend/busy got %b want 000", {received_flag, frame_pending, busy});
    end
    n_tests++;
    if ({parity_err, framing_err, overrun_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_errs: got %b want 000", {parity_err, framing_err, overrun_err});
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if ({busy, frame_pending} !== 2'b00) begin n_fail++; $display("FAIL post_reset_idle: got %b want 00", {busy, frame_pending}); end
  endtask

  task automatic test_basic;
    int f0;
    f0 = flag_cnt;
    send_frame(11'h54A, -1, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if (flag_cnt - f0 !== 1) begin n_fail++; $display("FAIL basic_flag: got %0d pulses want 1", flag_cnt - f0); end
    n_tests++;
    if (frame_out !== 11'h54A) begin n_fail++; $display("FAIL basic_frame: got %h want 54a", frame_out); end
    n_tests++;
    if ({parity_err, framing_err, overrun_err} !== 3'b000) begin
      n_fail++; $display("FAIL basic_errs: got %b want 000", {parity_err, framing_err, overrun_err});
    end
    n_tests++;
    if ({frame_pending, busy} !== 2'b10) begin n_fail++; $display("FAIL basic_pend_busy: got %b want 10", {frame_pending, busy}); end
    pulse_ack;
    n_tests++;
    if (frame_pending !== 1'b0) begin n_fail++; $display("FAIL basic_ack: pending got %b want 0", frame_pending); end
  endtask

  task automatic test_parity_err;
    send_frame(11'h74A, -1, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if (frame_out !== 11'h74A) begin n_fail++; $display("FAIL parity_frame: got %h want 74a", frame_out); end
    n_tests++;
    if ({parity_err, framing_err} !== 2'b10) begin n_fail++; $display("FAIL parity_errs: got %b want 10", {parity_err, framing_err}); end
    pulse_ack;
  endtask

  task automatic test_framing_break;
    int f0;
    f0 = flag_cnt;
    send_frame(11'h078, -1, -1, 1'b0);
    repeat (2560) @(negedge clk);
    n_tests++;
    if (flag_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_flag: got %0d pulses want 1", flag_cnt - f0); end
    n_tests++;
    if (frame_out !== 11'h078) begin n_fail++; $display("FAIL break_frame: got %h want 078", frame_out); end
    n_tests++;
    if ({parity_err, framing_err} !== 2'b01) begin n_fail++; $display("FAIL break_errs: got %b want 01", {parity_err, framing_err}); end
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL break_wait_busy: got %b want 1", busy); end
    rx_in = 1'b1;
    repeat (64) @(negedge clk);
    n_tests++;
    if ({busy, 1'b0} !== 2'b00 || flag_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL break_release: busy %b pulses %0d want busy 0 pulses 1", busy, flag_cnt - f0);
    end
    pulse_ack;
    send_frame(11'h54A, -1, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if (flag_cnt - f0 !== 2 || frame_out !== 11'h54A || framing_err !== 1'b0) begin
      n_fail++; $display("FAIL break_recover: pulses %0d frame %h ferr %b want 2 54a 0", flag_cnt - f0, frame_out, framing_err);
    end
    pulse_ack;
  endtask

  task automatic test_false_start;
    int f0;
    f0 = flag_cnt;
    @(negedge clk);
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL false_start_busy: got %b want 1", busy); end
    repeat (8) @(negedge clk);
    rx_in = 1'b1;
    repeat (128) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL false_start_idle: busy got %b want 0", busy); end
    n_tests++;
    if (flag_cnt - f0 !== 0) begin n_fail++; $display("FAIL false_start_flag: got %0d pulses want 0", flag_cnt - f0); end
  endtask

  task automatic test_overrun;
    int f0;
    f0 = flag_cnt;
    send_frame(11'h422, -1, -1, 1'b1);
    repeat (8) @(negedge clk);
    n_tests++;
    if ({frame_pending, overrun_err} !== 2'b10) begin n_fail++; $display("FAIL ovr_first: pend/ovr got %b want 10", {frame_pending, overrun_err}); end
    send_frame(11'h444, -1, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if (flag_cnt - f0 !== 2) begin n_fail++; $display("FAIL ovr_flags: got %0d pulses want 2", flag_cnt - f0); end
    n_tests++;
    if (frame_out !== 11'h444) begin n_fail++; $display("FAIL ovr_frame: got %h want 444", frame_out); end
    n_tests++;
    if ({frame_pending, overrun_err} !== 2'b11) begin n_fail++; $display("FAIL ovr_set: pend/ovr got %b want 11", {frame_pending, overrun_err}); end
    pulse_ack;
    n_tests++;
    if ({frame_pending, overrun_err} !== 2'b00) begin n_fail++; $display("FAIL ovr_ack: pend/ovr got %b want 00", {frame_pending, overrun_err}); end
    send_frame(11'h422, -1, -1, 1'b1);
    send_frame(11'h444, 674, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if ({frame_pending, overrun_err} !== 2'b10) begin n_fail++; $display("FAIL ovr_coincide: pend/ovr got %b want 10", {frame_pending, overrun_err}); end
    n_tests++;
    if (frame_out !== 11'h444) begin n_fail++; $display("FAIL ovr_coincide_frame: got %h want 444", frame_out); end
  endtask

  task automatic test_reset_midframe;
    int f0;
    f0 = flag_cnt;
    send_frame(11'h5FE, -1, 352, 1'b1);
    #1;
    n_tests++;
    if ({busy, frame_pending, received_flag} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_ctrl: busy/pend/flag got %b want 000", {busy, frame_pending, received_flag});
    end
    n_tests++;
    if (frame_out !== 11'h000 || {parity_err, framing_err, overrun_err} !== 3'b000) begin
      n_fail++; $display("FAIL rst_mid_data: frame %h errs %b want 000 000", frame_out, {parity_err, framing_err, overrun_err});
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (64) @(negedge clk);
    n_tests++;
    if (flag_cnt - f0 !== 0) begin n_fail++; $display("FAIL rst_mid_flag: got %0d pulses want 0", flag_cnt - f0); end
    send_frame(11'h4B4, -1, -1, 1'b1);
    repeat (16) @(negedge clk);
    n_tests++;
    if (frame_out !== 11'h4B4 || flag_cnt - f0 !== 1) begin
      n_fail++; $display("FAIL rst_mid_recover: frame %h pulses %0d want 4b4 1", frame_out, flag_cnt - f0);
    end
    n_tests++;
    if ({parity_err, framing_err, frame_pending} !== 3'b001) begin
      n_fail++; $display("FAIL rst_mid_status: perr/ferr/pend got %b want 001", {parity_err, framing_err, frame_pending});
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity_err;
    test_framing_break;
    test_false_start;
    test_overrun;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
